scene_recovery: RTL and testbench
=================================

// Module: scene_recovery
// PURPOSE
//  Final dehaze stage, directly downstream of the transmission-estimation top.
//  - Buffers raw RGB pixels until their transmission value arrives, then computes J = A + (I - A)*255/max(t,T0) per channel.
//  - Emits the recovered RGB pixel stream to the output/display path.
// PARAMETERS
//  FIFO_AW     10   pixel FIFO address width; depth = 2**FIFO_AW entries of 24 bits
//  T0          26   lower bound on transmission (~0.1*255); must be 1..255
//  RECIP_FB    12   fraction bits of the reciprocal (recip = floor(255*2**RECIP_FB / tc))
// PORTS
//  clk            in   1   single clock, rising edge
//  rst            in   1   asynchronous, active-high reset
//  input_pixel    in   24  raw pixel {R[23:16],G[15:8],B[7:0]}, same stream fed to the transmission stage
//  input_is_valid in   1   push input_pixel into the pixel FIFO
//  transmission   in   8   t, 0..255 represents 0..1
//  trans_valid    in   1   one t per cycle; pops the oldest buffered pixel
//  a_r,a_g,a_b    in   8   atmospheric light per channel
//  atm_valid      in   1   latch a_r/a_g/a_b
//  output_pixel   out  24  recovered pixel {R,G,B}
//  output_is_valid out 1   output_pixel valid this cycle
//  err_overflow   out  1   sticky: push dropped because FIFO full
//  err_underflow  out  1   sticky: trans_valid with FIFO empty
//  clip_count     out  16  saturated channel count (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, rst=1): FIFO empty, pointers 0, A regs = 8'hFF each, pipeline valids 0,
//   output_pixel=0, output_is_valid=0, err_*=0, clip_count=0. Reset mid-frame discards all buffered/in-flight pixels.
//  A regs: load on atm_valid; new A applies to pops in the same cycle and later (bypass: atm_valid with trans_valid uses new A).
//  FIFO: push on input_is_valid unless full; pop on trans_valid unless empty.
//   - full & push & pop same cycle: both happen, no overflow.
//   - full & push & !pop: push dropped, err_overflow<=1.
//   - empty & pop (even with simultaneous push): no pop, no output issued, err_underflow<=1.
//   - empty & push & !pop: normal push. Pointers wrap modulo 2**FIFO_AW; full/empty via extra wrap bit.
//  Pipeline (fixed, no stall; latency 4 cycles from accepted trans_valid to output_is_valid):
//   S1: read FIFO head I, register A; tc = (t < T0) ? T0 : t.
//   S2: recip = floor(255*2**RECIP_FB / tc) from 256-entry constant ROM (20 bits);
//       d_c = I_c - A_c, signed 9-bit.
//   S3: p_c = d_c * recip, signed 30-bit.
//   S4: q_c = p_c >>> RECIP_FB (arithmetic, floor); j_c = A_c + q_c;
//       j_c<0 -> 0, j_c>255 -> 255, else j_c; a clamp is a "clip" (0 or 255 reached exactly is not).
//  output_is_valid pulses one cycle per accepted pop, back-to-back allowed at 1 pixel/clk.
//  Output order equals input order; output_pixel holds last value while output_is_valid=0.
// CONFIGURATION
//  SR_CLIP_COUNT_EN defined: clip_count increments by number of clipped channels (0..3) per
//   output pixel, saturating at 16'hFFFF; cleared only by rst.
//  SR_CLIP_COUNT_EN undefined: clip_count tied to 16'd0, no counter logic.
// TESTING
//  A=(200,200,200), I=(100,150,250), t=128 -> 4 clk later out=(0,100,255); clip_count+1 (B only, macro on).
//  I=A=(80,90,100), t=10 (clamped to 26, recip=40172) -> out=(80,90,100), no clip.
//  Push 5 pixels, then 5 trans_valid back-to-back -> 5 consecutive valid outputs, same order, no errors.
//  Fill 2**FIFO_AW pixels, push one more without pop -> err_overflow=1; push+pop when full -> no error, count stays full.
//  trans_valid with empty FIFO -> no output_is_valid, err_underflow=1 (sticky until rst).
//  rst asserted with 3 pixels in flight -> outputs/flags 0 immediately; no stale output after release.

Source files
------------

// File: rtl/scene_recovery.sv
`timescale 1ns/1ps
// scene_recovery: final dehaze stage, J = A + (I - A)*255/max(t,T0) per channel.
// Optional saturating clip counter is built only when SR_CLIP_COUNT_EN is defined.
module scene_recovery #(
  parameter int FIFO_AW  = 10,
  parameter int T0       = 26,
  parameter int RECIP_FB = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] input_pixel,
  input  logic        input_is_valid,
  input  logic [7:0]  transmission,
  input  logic        trans_valid,
  input  logic [7:0]  a_r,
  input  logic [7:0]  a_g,
  input  logic [7:0]  a_b,
  input  logic        atm_valid,
  output logic [23:0] output_pixel,
  output logic        output_is_valid,
  output logic        err_overflow,
  output logic        err_underflow,
  output logic [15:0] clip_count
);
  localparam int         DEPTH = 1 << FIFO_AW;
  localparam logic [7:0] T0_C  = 8'(T0);

  logic [23:0]      mem_q [DEPTH];
  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             full_s, empty_s, push_s, pop_s;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic [23:0]      a_q, a_d, a_eff_s;

  logic             s1_v_q;
  logic [23:0]      s1_i_q, s1_a_q;
  logic [7:0]       s1_tc_q;
  logic             s2_v_q;
  logic [19:0]      s2_recip_q;
  logic signed [8:0] s2_d_q [3];
  logic [23:0]      s2_a_q;
  logic             s3_v_q;
  logic signed [29:0] s3_p_q [3];
  logic [23:0]      s3_a_q;
  logic signed [29:0] j_s [3];
  logic [23:0]      j_pix_s;
  logic [23:0]      out_pix_q;
  logic             out_v_q;

  // Reciprocal table; entries below T0 are never addressed since tc >= T0.
  logic [19:0] recip_rom_s [256];
  for (genvar k = 0; k < 256; k++) begin : g_rom
    localparam int DIV = (k < T0) ? T0 : k;
    assign recip_rom_s[k] = 20'((255 * (1 << RECIP_FB)) / DIV);
  end

  always_comb begin
    full_s   = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
               (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    empty_s  = (wr_ptr_q == rd_ptr_q);
    pop_s    = trans_valid && !empty_s;
    push_s   = input_is_valid && (!full_s || pop_s);
    wr_ptr_d = push_s ? wr_ptr_q + (FIFO_AW+1)'(1) : wr_ptr_q;
    rd_ptr_d = pop_s ? rd_ptr_q + (FIFO_AW+1)'(1) : rd_ptr_q;
    ovf_d    = ovf_q | (input_is_valid & full_s & ~pop_s);
    unf_d    = unf_q | (trans_valid & empty_s);
    a_eff_s  = atm_valid ? {a_r, a_g, a_b} : a_q;
    a_d      = a_eff_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      a_q      <= 24'hFFFFFF;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      a_q      <= a_d;
    end
  end

  // When full with push and pop together the read sees the old head before the overwrite.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q[FIFO_AW-1:0]] <= input_pixel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q     <= 1'b0;
      s1_i_q     <= 24'd0;
      s1_a_q     <= 24'd0;
      s1_tc_q    <= 8'd0;
      s2_v_q     <= 1'b0;
      s2_recip_q <= 20'd0;
      s2_a_q     <= 24'd0;
      s3_v_q     <= 1'b0;
      s3_a_q     <= 24'd0;
      out_v_q    <= 1'b0;
      out_pix_q  <= 24'd0;
      for (int c = 0; c < 3; c++) begin
        s2_d_q[c] <= 9'sd0;
        s3_p_q[c] <= 30'sd0;
      end
    end else begin
      s1_v_q     <= pop_s;
      s1_i_q     <= mem_q[rd_ptr_q[FIFO_AW-1:0]];
      s1_a_q     <= a_eff_s;
      s1_tc_q    <= (transmission < T0_C) ? T0_C : transmission;
      s2_v_q     <= s1_v_q;
      s2_recip_q <= recip_rom_s[s1_tc_q];
      s2_a_q     <= s1_a_q;
      s3_v_q     <= s2_v_q;
      s3_a_q     <= s2_a_q;
      out_v_q    <= s3_v_q;
      for (int c = 0; c < 3; c++) begin
        s2_d_q[c] <= $signed({1'b0, s1_i_q[8*c +: 8]}) - $signed({1'b0, s1_a_q[8*c +: 8]});
        s3_p_q[c] <= $signed(30'(s2_d_q[c])) * $signed(30'({1'b0, s2_recip_q}));
      end
      if (s3_v_q) begin
        out_pix_q <= j_pix_s;
      end
    end
  end

  // Arithmetic shift floors toward -inf, then clamp to the 8-bit range.
  always_comb begin
    j_pix_s = 24'd0;
    for (int c = 0; c < 3; c++) begin
      j_s[c] = (s3_p_q[c] >>> RECIP_FB) + $signed(30'(s3_a_q[8*c +: 8]));
      if (j_s[c][29]) begin
        j_pix_s[8*c +: 8] = 8'd0;
      end else if (j_s[c] > 30'sd255) begin
        j_pix_s[8*c +: 8] = 8'd255;
      end else begin
        j_pix_s[8*c +: 8] = j_s[c][7:0];
      end
    end
  end

`ifdef SR_CLIP_COUNT_EN
  logic [2:0]  clip_s;
  logic [16:0] clip_sum_s;
  logic [15:0] clip_q;

  always_comb begin
    clip_s = 3'd0;
    for (int c = 0; c < 3; c++) begin
      clip_s[c] = j_s[c][29] || (j_s[c] > 30'sd255);
    end
    clip_sum_s = {1'b0, clip_q} + 17'(clip_s[0]) + 17'(clip_s[1]) + 17'(clip_s[2]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clip_q <= 16'd0;
    end else if (s3_v_q) begin
      clip_q <= clip_sum_s[16] ? 16'hFFFF : clip_sum_s[15:0];
    end
  end

  assign clip_count = clip_q;
`else
  assign clip_count = 16'd0;
`endif

  assign output_pixel    = out_pix_q;
  assign output_is_valid = out_v_q;
  assign err_overflow    = ovf_q;
  assign err_underflow   = unf_q;

endmodule

// File: tb/tb_scene_recovery.sv
`timescale 1ns/1ps
// Directed bench for scene_recovery: reference FIFO + arithmetic model feed a scoreboard queue.
module tb_scene_recovery;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] input_pixel;
  logic        input_is_valid;
  logic [7:0]  transmission;
  logic        trans_valid;
  logic [7:0]  a_r, a_g, a_b;
  logic        atm_valid;
  logic [23:0] output_pixel;
  logic        output_is_valid;
  logic        err_overflow;
  logic        err_underflow;
  logic [15:0] clip_count;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [23:0] pix_q [$];
  logic [23:0] exp_q [$];
  logic [23:0] a_model  = 24'hFFFFFF;
  logic [23:0] mon_exp;
  bit          ovf_exp  = 1'b0;
  bit          unf_exp  = 1'b0;
  int          clip_exp = 0;

  always #5 clk = ~clk;

  scene_recovery dut (
    .clk(clk), .rst(rst),
    .input_pixel(input_pixel), .input_is_valid(input_is_valid),
    .transmission(transmission), .trans_valid(trans_valid),
    .a_r(a_r), .a_g(a_g), .a_b(a_b), .atm_valid(atm_valid),
    .output_pixel(output_pixel), .output_is_valid(output_is_valid),
    .err_overflow(err_overflow), .err_underflow(err_underflow),
    .clip_count(clip_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] model_j(input logic [23:0] pix, input logic [23:0] a,
                                          input logic [7:0] t, output int clips);
    int tc, recip, d, p, q, j;
    logic [23:0] r;
    tc    = (t < 8'd26) ? 26 : int'(t);
    recip = (255 * 4096) / tc;
    clips = 0;
    r     = 24'd0;
    for (int c = 0; c < 3; c++) begin
      d = int'(pix[8*c +: 8]) - int'(a[8*c +: 8]);
      p = d * recip;
      q = (p >= 0) ? p / 4096 : -((-p + 4095) / 4096);
      j = int'(a[8*c +: 8]) + q;
      if (j < 0) begin j = 0; clips++; end
      else if (j > 255) begin j = 255; clips++; end
      r[8*c +: 8] = 8'(j);
    end
    return r;
  endfunction

  function automatic int clip_expected();
`ifdef SR_CLIP_COUNT_EN
    return clip_exp;
`else
    return 0;
`endif
  endfunction

  // One clock of stimulus; the reference model is updated with what the DUT samples.
  task automatic step(input bit push, input logic [23:0] pix, input bit tv,
                      input logic [7:0] t, input bit av, input logic [23:0] a);
    bit full, empty, do_pop, do_push;
    int clips;
    logic [23:0] head, j;
    input_is_valid = push; input_pixel = pix;
    trans_valid = tv; transmission = t;
    atm_valid = av; {a_r, a_g, a_b} = a;
    if (av) a_model = a;
    full    = (pix_q.size() == DEPTH);
    empty   = (pix_q.size() == 0);
    do_pop  = tv && !empty;
    do_push = push && (!full || do_pop);
    if (push && full && !do_pop) ovf_exp = 1'b1;
    if (tv && empty) unf_exp = 1'b1;
    if (do_pop) begin
      head = pix_q.pop_front();
      j = model_j(head, a_model, t, clips);
      exp_q.push_back(j);
      clip_exp = (clip_exp + clips > 65535) ? 65535 : clip_exp + clips;
    end
    if (do_push) pix_q.push_back(pix);
    @(posedge clk); #1;
    input_is_valid = 1'b0; trans_valid = 1'b0; atm_valid = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 24'd0, 1'b0, 8'd0, 1'b0, 24'd0);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard: every valid output must match the oldest expected pixel.
  always @(negedge clk) begin
    if (rst === 1'b0 && output_is_valid === 1'b1) begin
      check("unexpected_output", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        check("out_pixel", 32'(output_pixel), 32'(mon_exp));
      end
    end
  end

  logic [23:0] vec_pix [5];
  logic [7:0]  vec_t   [5];

  initial begin
    rst = 1'b1; input_pixel = 24'd0; input_is_valid = 1'b0; transmission = 8'd0;
    trans_valid = 1'b0; a_r = 8'd0; a_g = 8'd0; a_b = 8'd0; atm_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pixel", 32'(output_pixel), 32'd0);
    check("rst_valid", 32'(output_is_valid), 32'd0);
    check("rst_ovf", 32'(err_overflow), 32'd0);
    check("rst_unf", 32'(err_underflow), 32'd0);
    check("rst_clip", 32'(clip_count), 32'd0);
    rst = 1'b0;

    // A=200, I=(100,150,250), t=128 -> (0,100,255), latency 4 clocks
    step(1'b0, 24'd0, 1'b0, 8'd0, 1'b1, 24'hC8C8C8);
    step(1'b1, 24'h6496FA, 1'b0, 8'd0, 1'b0, 24'd0);
    step(1'b0, 24'd0, 1'b1, 8'd128, 1'b0, 24'd0);
    idle(); idle();
    check("lat_early", 32'(output_is_valid), 32'd0);
    idle();
    check("lat_valid", 32'(output_is_valid), 32'd1);
    check("ex1_pixel", 32'(output_pixel), 32'h0064FF);
    wait_drain("drain_ex1");
    check("ex1_clip", 32'(clip_count), 32'(clip_expected()));

    // I=A=(80,90,100), t=10 with A loaded in the same cycle as the pop
    step(1'b1, 24'h505A64, 1'b0, 8'd0, 1'b0, 24'd0);
    step(1'b0, 24'd0, 1'b1, 8'd10, 1'b1, 24'h505A64);
    idle(); idle(); idle();
    check("ex2_pixel", 32'(output_pixel), 32'h505A64);
    wait_drain("drain_ex2");
    check("ex2_clip", 32'(clip_count), 32'(clip_expected()));

    // Five back-to-back pops with extreme pixels and t at the clamp boundary
    vec_pix[0] = 24'h000000; vec_pix[1] = 24'hFFFFFF; vec_pix[2] = 24'h123456;
    vec_pix[3] = 24'h80FF01; vec_pix[4] = 24'hA5C3E7;
    vec_t[0] = 8'd0; vec_t[1] = 8'd255; vec_t[2] = 8'd26; vec_t[3] = 8'd25; vec_t[4] = 8'd200;
    for (int i = 0; i < 5; i++) step(1'b1, vec_pix[i], 1'b0, 8'd0, (i == 0), 24'h804020);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 24'd0, 1'b1, vec_t[i], 1'b0, 24'd0);
      if (i >= 3) check("b2b_valid", 32'(output_is_valid), 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      idle();
      check("b2b_valid", 32'(output_is_valid), 32'd1);
    end
    idle();
    check("b2b_end", 32'(output_is_valid), 32'd0);
    wait_drain("drain_b2b");
    check("b2b_ovf", 32'(err_overflow), 32'(ovf_exp));
    check("b2b_unf", 32'(err_underflow), 32'(unf_exp));
    check("b2b_clip", 32'(clip_count), 32'(clip_expected()));

    // Underflow: pop on empty, then pop+push on empty (push only)
    step(1'b0, 24'd0, 1'b1, 8'd100, 1'b0, 24'd0);
    check("unf_set", 32'(err_underflow), 32'd1);
    step(1'b1, 24'h0A0B0C, 1'b1, 8'd50, 1'b0, 24'd0);
    idle(); idle(); idle();
    check("unf_sticky", 32'(err_underflow), 32'd1);
    check("unf_no_out", 32'(exp_q.size()), 32'd0);
    step(1'b0, 24'd0, 1'b1, 8'd50, 1'b0, 24'd0);
    wait_drain("drain_unf");

    // Fill to full, push+pop at full, then overflow, then drain in order
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 24'($urandom), 1'b0, 8'd0, (i == 0), 24'h40A0E0);
    check("full_no_ovf", 32'(err_overflow), 32'd0);
    step(1'b1, 24'($urandom), 1'b1, 8'($urandom), 1'b0, 24'd0);
    check("full_pushpop", 32'(err_overflow), 32'd0);
    step(1'b1, 24'($urandom), 1'b0, 8'd0, 1'b0, 24'd0);
    check("ovf_set", 32'(err_overflow), 32'd1);
    check("ovf_model", 32'(err_overflow), 32'(ovf_exp));
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, 24'd0, 1'b1, 8'($urandom), 1'b0, 24'd0);
    wait_drain("drain_full");
    check("full_clip", 32'(clip_count), 32'(clip_expected()));

    // Reset with three pixels in flight
    for (int i = 0; i < 3; i++) step(1'b1, 24'($urandom), 1'b0, 8'd0, 1'b0, 24'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 24'd0, 1'b1, 8'd60, 1'b0, 24'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(output_is_valid), 32'd0);
    check("mid_rst_pixel", 32'(output_pixel), 32'd0);
    check("mid_rst_ovf", 32'(err_overflow), 32'd0);
    check("mid_rst_unf", 32'(err_underflow), 32'd0);
    check("mid_rst_clip", 32'(clip_count), 32'd0);
    exp_q.delete(); pix_q.delete();
    a_model = 24'hFFFFFF; ovf_exp = 1'b0; unf_exp = 1'b0; clip_exp = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) idle();
    check("post_rst_quiet", 32'(output_is_valid), 32'd0);

    // Default A after reset
    step(1'b1, 24'h336699, 1'b0, 8'd0, 1'b0, 24'd0);
    step(1'b0, 24'd0, 1'b1, 8'd77, 1'b0, 24'd0);
    wait_drain("drain_post_rst");
    check("post_rst_clip", 32'(clip_count), 32'(clip_expected()));
    check("post_rst_unf", 32'(err_underflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
